regfile_dec: RTL and testbench

Parametrised register file built around a one-hot write-address decoder. It generalises the fixed 5-to-32 register-address decoder into a complete storage block. The block provides a configurable register count and data width, one decoded write port, and two registered read ports. It also reports out-of-range accesses through a sticky error flag. It sits between instruction decode and the datapath, and is the register storage the CPU core instantiates.

---
 rtl/regfile_dec.sv | 102 ++++++++++
 tb/tb_regfile_dec.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_dec.sv
// Register file with a one-hot write-address decoder, two registered read ports and a sticky address-error flag.
// Optional write-first forwarding on same-cycle read/write: define REGFILE_BYPASS_EN.
module regfile_dec #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                re,
    input  logic [ADDR_W-1:0]   raddr_a,
    input  logic [ADDR_W-1:0]   raddr_b,
    output logic [DATA_W-1:0]   rdata_a,
    output logic [DATA_W-1:0]   rdata_b,
    output logic                rvalid,
    output logic [NUM_REGS-1:0] wr_strobe,
    output logic                addr_err,
    input  logic                err_clr
);

    localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] writeDec;
    logic [NUM_REGS-1:0] writeEn;
    logic                writeAcc;
    logic                errSet;
    logic [DATA_W-1:0]   rdNextA;
    logic [DATA_W-1:0]   rdNextB;

    function automatic logic inRange(input logic [ADDR_W-1:0] addr);
        return 32'(addr) < NUM_REGS;
    endfunction

    // Register 0 is hard-wired to zero when ZERO_REG is set.
    function automatic logic readOk(input logic [ADDR_W-1:0] addr);
        return inRange(addr) && !(ZERO_REG != 0 && addr == '0);
    endfunction

    // One-hot write decode; all-zero for out-of-range or the zero register.
    always_comb begin
        writeDec = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (waddr == ADDR_W'(i) && !(ZERO_REG != 0 && i == 0)) begin
                writeDec[IDX_W'(i)] = 1'b1;
            end
        end
    end

    assign writeAcc = we && (writeDec != '0);
    assign writeEn  = writeAcc ? writeDec : '0;
    assign errSet   = (we && !inRange(waddr)) ||
                      (re && (!inRange(raddr_a) || !inRange(raddr_b)));

    // Read data selection; out-of-range and zero-register reads return 0.
    always_comb begin
        rdNextA = '0;
        rdNextB = '0;
        if (readOk(raddr_a)) rdNextA = regs[IDX_W'(raddr_a)];
        if (readOk(raddr_b)) rdNextB = regs[IDX_W'(raddr_b)];
`ifdef REGFILE_BYPASS_EN
        if (readOk(raddr_a) && writeAcc && raddr_a == waddr) rdNextA = wdata;
        if (readOk(raddr_b) && writeAcc && raddr_b == waddr) rdNextB = wdata;
`endif
    end

    // Storage array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs[IDX_W'(i)] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (writeEn[IDX_W'(i)]) regs[IDX_W'(i)] <= wdata;
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_a   <= '0;
            rdata_b   <= '0;
            rvalid    <= 1'b0;
            wr_strobe <= '0;
            addr_err  <= 1'b0;
        end else begin
            rvalid    <= re;
            wr_strobe <= writeEn;
            if (re) begin
                rdata_a <= rdNextA;
                rdata_b <= rdNextB;
            end
            if (errSet) addr_err <= 1'b1;
            else if (err_clr) addr_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_dec.sv
// Scoreboard bench for regfile_dec (NUM_REGS=24): directed reads queue expected data, a negedge monitor checks it.
module tb_regfile_dec;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic        re = 1'b0;
    logic [4:0]  raddr_a = '0;
    logic [4:0]  raddr_b = '0;
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;
    logic        rvalid;
    logic [23:0] wr_strobe;
    logic        addr_err;
    logic        err_clr = 1'b0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    bit   monOn  = 1'b1;

`ifdef REGFILE_BYPASS_EN
    localparam logic [31:0] SAME7 = 32'h22;
`else
    localparam logic [31:0] SAME7 = 32'h11;
`endif

    regfile_dec #(.DATA_W(32), .NUM_REGS(24), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr_a(raddr_a), .raddr_b(raddr_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b), .rvalid(rvalid),
        .wr_strobe(wr_strobe), .addr_err(addr_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every valid read result is compared with the oldest expectation.
    always @(negedge clk) begin
        if (monOn && rvalid) begin
            if (expQ.size() == 0) begin
                chk("rd_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                chk("rdata_a", rdata_a, e.a);
                chk("rdata_b", rdata_b, e.b);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic iwe, input logic [4:0] iwa, input logic [31:0] iwd,
                         input logic ire, input logic [4:0] ira, input logic [4:0] irb,
                         input logic [31:0] ea, input logic [31:0] eb, input logic iclr);
        exp_t e;
        we = iwe; waddr = iwa; wdata = iwd;
        re = ire; raddr_a = ira; raddr_b = irb; err_clr = iclr;
        if (ire) begin
            e.a = ea;
            e.b = eb;
            expQ.push_back(e);
        end
        tick();
    endtask

    task automatic idle();
        issue(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic chkOutputsZero(input string tag);
        chk({tag, "_rdata_a"}, rdata_a, 32'h0);
        chk({tag, "_rdata_b"}, rdata_b, 32'h0);
        chk({tag, "_rvalid"}, 32'(rvalid), 32'h0);
        chk({tag, "_wr_strobe"}, 32'(wr_strobe), 32'h0);
        chk({tag, "_addr_err"}, 32'(addr_err), 32'h0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2 chkOutputsZero("reset");
        tick();
        tick();
        #3 rst_n = 1'b1;
        tick();

        // Write then read back, strobe for exactly one cycle.
        issue(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
        chk("strobe_w5", 32'(wr_strobe), 32'h0000_0020);
        issue(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 1'b0);
        chk("strobe_off", 32'(wr_strobe), 32'h0);

        // Zero register: dropped write, no strobe, no error.
        issue(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
        chk("strobe_w0", 32'(wr_strobe), 32'h0);
        chk("err_w0", 32'(addr_err), 32'h0);
        issue(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
        chk("err_r0", 32'(addr_err), 32'h0);

        // Same-cycle read/write of reg 7.
        issue(1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
        issue(1'b1, 5'd7, 32'h22, 1'b1, 5'd7, 5'd5, SAME7, 32'hDEADBEEF, 1'b0);
        chk("strobe_w7", 32'(wr_strobe), 32'h0000_0080);
        issue(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 32'h22, 32'h22, 1'b0);

        // Parallel reads of the same address, then hold with re low.
        issue(1'b1, 5'd3, 32'hA5A5_0003, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
        issue(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 32'hA5A5_0003, 32'hA5A5_0003, 1'b0);
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("hold_rvalid", 32'(rvalid), 32'h0);
            chk("hold_a", rdata_a, 32'hA5A5_0003);
            chk("hold_b", rdata_b, 32'hA5A5_0003);
        end

        // Out-of-range write and read.
        issue(1'b1, 5'd30, 32'h0BAD_0BAD, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0);
        chk("strobe_w30", 32'(wr_strobe), 32'h0);
        chk("err_w30", 32'(addr_err), 32'h1);
        issue(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd29, 32'hDEADBEEF, 32'h0, 1'b0);
        chk("err_r29", 32'(addr_err), 32'h1);
        idle();
        idle();
        chk("err_sticky", 32'(addr_err), 32'h1);
        issue(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd7, 32'hA5A5_0003, 32'h22, 1'b0);
        issue(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 5'd14, 32'h0, 32'h0, 1'b0);
        issue(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1);
        chk("err_clr", 32'(addr_err), 32'h0);
        issue(1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 5'd3, 32'h0, 32'hA5A5_0003, 1'b1);
        chk("err_set_wins", 32'(addr_err), 32'h1);
        issue(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1);
        chk("err_clr2", 32'(addr_err), 32'h0);
        idle();
        chk("queue_drained", 32'(expQ.size()), 32'h0);

        // Random traffic, then reset in the middle of a cycle.
        monOn = 1'b0;
        for (int i = 0; i < 20; i++) begin
            we = 1'b1; waddr = 5'($urandom_range(1, 31)); wdata = $urandom | 32'h1;
            re = 1'b1; raddr_a = 5'($urandom_range(0, 31)); raddr_b = 5'($urandom_range(0, 31));
            err_clr = 1'b0;
            tick();
        end
        #2 rst_n = 1'b0;
        #1 chkOutputsZero("midreset");
        expQ.delete();
        we = 1'b0; re = 1'b0;
        monOn = 1'b1;
        tick();
        #3 rst_n = 1'b1;
        tick();
        for (int i = 0; i < 24; i++) begin
            issue(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 5'(23 - i), 32'h0, 32'h0, 1'b0);
        end
        idle();
        idle();
        chk("post_reset_err", 32'(addr_err), 32'h0);
        chk("final_queue", 32'(expQ.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
